// File: rtl/rnn_seq_sequencer.sv
// Timestep sequencer for the recurrent hidden layer: owns h, drives the hidden2hidden datapath, folds in x_proj.
// Optional feature macro: RNN_SEQ_HARDTANH_EN (clamp each updated element to +/-1.0 instead of the BW range).
module rnn_seq_sequencer #(
    parameter int HIDDEN_SIZE   = 20,
    parameter int BW            = 32,
    parameter int FRAC          = 15,
    parameter int SEQ_LEN_W     = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [SEQ_LEN_W-1:0]        seq_len,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic [HIDDEN_SIZE*BW-1:0]   x_proj_bus,
    output logic [HIDDEN_SIZE*BW-1:0]   h2h_in_bus,
    input  logic [HIDDEN_SIZE*BW-1:0]   h2h_out_bus,
    output logic [HIDDEN_SIZE*BW-1:0]   h_out_bus,
    output logic                        h_valid,
    output logic [SEQ_LEN_W-1:0]        step_idx,
    output logic                        busy,
    output logic                        done
);

    localparam int VW    = HIDDEN_SIZE * BW;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

`ifdef RNN_SEQ_HARDTANH_EN
    localparam logic signed [BW:0] SAT_HI = $signed({{(BW-FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}});
    localparam logic signed [BW:0] SAT_LO = -SAT_HI;
`else
    localparam logic signed [BW:0] SAT_HI = $signed({2'b00, {(BW-1){1'b1}}});
    localparam logic signed [BW:0] SAT_LO = $signed({2'b11, {(BW-1){1'b0}}});
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_X = 3'd1,
        S_SETTLE = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [VW-1:0]          h_r;
    logic [VW-1:0]          x_reg_r;
    logic [VW-1:0]          h_upd_s;
    logic [SEQ_LEN_W-1:0]   step_idx_r;
    logic [SEQ_LEN_W-1:0]   len_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   h_valid_r;
    logic                   done_r;
    logic                   last_step_s;

    function automatic logic [BW-1:0] sat_elem(input logic signed [BW:0] s);
        logic [BW-1:0] r;
        if (s > SAT_HI) begin
            r = SAT_HI[BW-1:0];
        end else if (s < SAT_LO) begin
            r = SAT_LO[BW-1:0];
        end else begin
            r = s[BW-1:0];
        end
        return r;
    endfunction

    assign last_step_s = (step_idx_r == (len_r - SEQ_LEN_W'(1)));

    // Per-element widened sum of the latched projection and datapath result, then saturated
    always_comb begin
        logic signed [BW:0] sum_v;
        sum_v   = '0;
        h_upd_s = '0;
        for (int i = 0; i < HIDDEN_SIZE; i++) begin
            sum_v = $signed({x_reg_r[i*BW+BW-1], x_reg_r[i*BW +: BW]})
                  + $signed({h2h_out_bus[i*BW+BW-1], h2h_out_bus[i*BW +: BW]});
            h_upd_s[i*BW +: BW] = sat_elem(sum_v);
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (seq_len != '0) begin
                        state_next_s = S_WAIT_X;
                    end else begin
                        state_next_s = S_DONE;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WAIT_X: begin
                if (x_valid) begin
                    state_next_s = S_SETTLE;
                end else begin
                    state_next_s = S_WAIT_X;
                end
            end
            S_SETTLE: begin
                if (cnt_r == '0) begin
                    state_next_s = S_UPDATE;
                end else begin
                    state_next_s = S_SETTLE;
                end
            end
            S_UPDATE: begin
                if (last_step_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_WAIT_X;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register and the registered status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            h_valid_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            h_valid_r <= (state_r == S_UPDATE);
            done_r    <= (state_next_s == S_DONE);
        end
    end

    // Hidden state, projection latch, step bookkeeping and settle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            h_r        <= '0;
            x_reg_r    <= '0;
            step_idx_r <= '0;
            len_r      <= '0;
            cnt_r      <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start && (seq_len != '0)) begin
                        h_r        <= '0;
                        step_idx_r <= '0;
                        len_r      <= seq_len;
                    end
                end
                S_WAIT_X: begin
                    if (x_valid) begin
                        x_reg_r <= x_proj_bus;
                        cnt_r   <= CNT_LOAD;
                    end
                end
                S_SETTLE: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                S_UPDATE: begin
                    h_r <= h_upd_s;
                    if (!last_step_s) begin
                        step_idx_r <= step_idx_r + SEQ_LEN_W'(1);
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign x_ready    = (state_r == S_WAIT_X);
    assign busy       = (state_r == S_WAIT_X) || (state_r == S_SETTLE) || (state_r == S_UPDATE);
    assign h2h_in_bus = h_r;
    assign h_out_bus  = h_r;
    assign h_valid    = h_valid_r;
    assign done       = done_r;
    assign step_idx   = step_idx_r;

endmodule

// File: tb/tb_rnn_seq_sequencer.sv
// Directed bench for rnn_seq_sequencer: models the hidden2hidden datapath and scores h against a queue.
module tb_rnn_seq_sequencer;

    localparam int HS = 20;
    localparam int BW = 32;
    localparam int VW = HS * BW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [7:0]      seq_len = 8'd0;
    logic            x_valid = 1'b0;
    logic            x_ready;
    logic [VW-1:0]   x_proj_bus = '0;
    logic [VW-1:0]   h2h_in_bus;
    logic [VW-1:0]   h2h_out_bus;
    logic [VW-1:0]   h_out_bus;
    logic            h_valid;
    logic [7:0]      step_idx;
    logic            busy;
    logic            done;

    int vectors = 0;
    int miscompares = 0;
    int hv_cnt = 0;
    int done_cnt = 0;

    logic                  h2h_mode = 1'b0;
    logic signed [BW-1:0]  h2h_const [HS];
    logic signed [BW-1:0]  xv [HS];
    logic signed [BW-1:0]  model_h [HS];
    logic [VW-1:0]         sb_q [$];

    rnn_seq_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .seq_len(seq_len),
        .x_valid(x_valid), .x_ready(x_ready), .x_proj_bus(x_proj_bus),
        .h2h_in_bus(h2h_in_bus), .h2h_out_bus(h2h_out_bus), .h_out_bus(h_out_bus),
        .h_valid(h_valid), .step_idx(step_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: either a constant vector or h/2 per element
    always_comb begin
        h2h_out_bus = '0;
        for (int i = 0; i < HS; i++) begin
            if (h2h_mode) h2h_out_bus[(HS-1-i)*BW +: BW] = $signed(h2h_in_bus[(HS-1-i)*BW +: BW]) >>> 1;
            else          h2h_out_bus[(HS-1-i)*BW +: BW] = h2h_const[i];
        end
    end

    always @(negedge clk) begin
        if (h_valid) hv_cnt <= hv_cnt + 1;
        if (done)    done_cnt <= done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic signed [BW-1:0] model_sat(input longint s);
`ifdef RNN_SEQ_HARDTANH_EN
        if (s > 64'sd32768)  return 32'sd32768;
        if (s < -64'sd32768) return -32'sd32768;
`else
        if (s > 64'sd2147483647)  return 32'sh7FFFFFFF;
        if (s < -64'sd2147483648) return 32'sh80000000;
`endif
        return s[BW-1:0];
    endfunction

    function automatic logic [VW-1:0] pack(input logic signed [BW-1:0] a [HS]);
        logic [VW-1:0] b;
        for (int i = 0; i < HS; i++) b[(HS-1-i)*BW +: BW] = a[i];
        return b;
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic [7:0] len);
        start = 1'b1;
        seq_len = len;
        tick();
        start = 1'b0;
        seq_len = 8'hA5;
        chk("busy_after_start", busy, len != 8'd0);
        chk("x_ready_after_start", x_ready, len != 8'd0);
        chk("done_after_start", done, len == 8'd0);
        if (len != 8'd0) for (int i = 0; i < HS; i++) model_h[i] = '0;
    endtask

    task automatic do_step(input int idle_cycles, input logic [7:0] exp_idx, input bit is_last, input bit poke_start);
        logic [VW-1:0] exp_bus;
        logic signed [BW-1:0] hh;
        int n;
        for (int c = 0; c < idle_cycles; c++) begin
            chk("x_ready_wait", x_ready, 1'b1);
            tick();
        end
        chk("x_ready_hs", x_ready, 1'b1);
        chk("step_idx_hs", step_idx, exp_idx);
        for (int i = 0; i < HS; i++) begin
            hh = h2h_mode ? (model_h[i] >>> 1) : h2h_const[i];
            model_h[i] = model_sat(longint'(xv[i]) + longint'(hh));
        end
        sb_q.push_back(pack(model_h));
        x_valid = 1'b1;
        x_proj_bus = pack(xv);
        tick();
        x_valid = 1'b0;
        x_proj_bus = {20{$urandom()}};
        n = 0;
        if (poke_start) begin
            start = 1'b1;
            seq_len = 8'd9;
            tick();
            start = 1'b0;
            n = 1;
            chk("busy_after_poke", busy, 1'b1);
        end
        while (!h_valid && n < 20) begin
            tick();
            n++;
        end
        chk("h_valid_latency", n, 2);
        exp_bus = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        chk("h_out", h_out_bus, exp_bus);
        chk("h2h_in", h2h_in_bus, exp_bus);
        chk("done_at_hvalid", done, is_last);
        chk("busy_at_hvalid", busy, !is_last);
        chk("step_idx_after", step_idx, is_last ? exp_idx : exp_idx + 8'd1);
    endtask

    task automatic end_checks();
        tick();
        chk("done_cleared", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_x_ready", x_ready, 1'b0);
        chk("h_retained", h_out_bus, pack(model_h));
    endtask

    initial begin
        int hv0, d0;
        for (int i = 0; i < HS; i++) begin
            h2h_const[i] = '0;
            xv[i] = '0;
            model_h[i] = '0;
        end

        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst_h_out", h_out_bus, '0);
        chk("rst_h2h_in", h2h_in_bus, '0);
        chk("rst_x_ready", x_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_h_valid", h_valid, 1'b0);
        chk("rst_step_idx", step_idx, 8'd0);
        rst = 1'b0;
        tick();

        // Single step
        for (int i = 0; i < HS; i++) xv[i] = 32'sd16384;
        start_seq(8'd1);
        do_step(0, 8'd0, 1'b1, 1'b0);
        end_checks();

        // Saturation positive / negative
        for (int i = 0; i < HS; i++) begin xv[i] = 32'sd24576; h2h_const[i] = 32'sd16384; end
        start_seq(8'd1);
        do_step(0, 8'd0, 1'b1, 1'b0);
        end_checks();
        for (int i = 0; i < HS; i++) begin xv[i] = -32'sd24576; h2h_const[i] = -32'sd16384; end
        start_seq(8'd1);
        do_step(0, 8'd0, 1'b1, 1'b0);
        end_checks();

        // Range extremes alternating sign, and distinct per-element values
        for (int i = 0; i < HS; i++) begin
            xv[i]        = (i % 2 == 0) ? 32'sh7FFF0000 : 32'sh80000000;
            h2h_const[i] = (i % 2 == 0) ? 32'sh7FFF0000 : -32'sd5;
        end
        start_seq(8'd1);
        do_step(0, 8'd0, 1'b1, 1'b0);
        end_checks();
        for (int i = 0; i < HS; i++) begin
            xv[i]        = 32'(i * 1000 - 5000);
            h2h_const[i] = 32'(i * 7 - 60);
        end
        start_seq(8'd1);
        do_step(1, 8'd0, 1'b1, 1'b0);
        end_checks();

        // seq_len=3 with backpressure, datapath h/2, start pulsed during SETTLE
        h2h_mode = 1'b1;
        for (int i = 0; i < HS; i++) xv[i] = 32'sd16384;
        hv0 = hv_cnt;
        d0 = done_cnt;
        start_seq(8'd3);
        do_step(5, 8'd0, 1'b0, 1'b0);
        do_step(5, 8'd1, 1'b0, 1'b1);
        do_step(5, 8'd2, 1'b1, 1'b0);
        end_checks();
        tick();
        chk("hvalid_pulses", hv_cnt - hv0, 3);
        chk("done_pulses", done_cnt - d0, 1);

        // seq_len=0: immediate done, h unchanged
        start_seq(8'd0);
        chk("len0_h", h_out_bus, pack(model_h));
        end_checks();

        // Reset during step 1 of a 4-step sequence
        start_seq(8'd4);
        do_step(0, 8'd0, 1'b0, 1'b0);
        x_valid = 1'b1;
        x_proj_bus = pack(xv);
        tick();
        x_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < HS; i++) model_h[i] = '0;
        d0 = done_cnt;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_x_ready", x_ready, 1'b0);
        chk("midrst_h", h_out_bus, '0);
        chk("midrst_step_idx", step_idx, 8'd0);
        chk("midrst_h_valid", h_valid, 1'b0);
        for (int c = 0; c < 4; c++) tick();
        chk("midrst_no_done", done_cnt - d0, 0);

        // New sequence afterwards
        for (int i = 0; i < HS; i++) xv[i] = 32'(-3000 + i * 411);
        start_seq(8'd2);
        do_step(2, 8'd0, 1'b0, 1'b0);
        do_step(0, 8'd1, 1'b1, 1'b0);
        end_checks();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
